// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: port IDs, lock FSM
// encodings, grant decision encoding and default tuning parameters.
package mem_pkg;

    // Default number of back-to-back core grants the IO port tolerates.
    localparam int STARVE_LIMIT_DEF = 3;
    // Default maximum number of cycles the core may hold the lock.
    localparam int LOCK_MAX_DEF     = 8;

    // Requester IDs; also used to tag an outstanding read.
    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_IO   = 1'b1
    } port_e;

    // Lock FSM states.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Outcome of the per-cycle arbitration decision.
    typedef enum logic [1:0] {
        PICK_IDLE = 2'd0,
        PICK_CORE = 2'd1,
        PICK_IO   = 2'd2
    } pick_e;

    // Counter width able to hold max_val, never narrower than 2 bits.
    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 2) ? 2 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the single memory port.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    // Core requester
    logic          Req0;
    logic          Write0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] WData0;
    logic          Lock0;
    logic          Gnt0;
    logic          RValid0;
    logic [DW-1:0] RData0;

    // IO requester
    logic          Req1;
    logic          Write1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData1;
    logic          Gnt1;
    logic          RValid1;
    logic [DW-1:0] RData1;

    // Shared memory port
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] MemRData;

    // Forced lock release indication
    logic          LockErr;

    modport slave (
        input  Req0, Write0, Addr0, WData0, Lock0,
        input  Req1, Write1, Addr1, WData1,
        input  MemRData,
        output Gnt0, RValid0, RData0,
        output Gnt1, RValid1, RData1,
        output MemAddr, MemWData, MemRead, MemWrite,
        output LockErr
    );

    modport master (
        output Req0, Write0, Addr0, WData0, Lock0,
        output Req1, Write1, Addr1, WData1,
        output MemRData,
        input  Gnt0, RValid0, RData0,
        input  Gnt1, RValid1, RData1,
        input  MemAddr, MemWData, MemRead, MemWrite,
        input  LockErr
    );

endinterface

// File: rtl/arb_pick.sv
// Purely combinational priority/starvation decision for the memory port.
// Lock wins outright, then a starved or uncontested IO request, then the core.
module arb_pick
    import mem_pkg::*;
#(
    parameter int SW           = 2,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_locked,
    input  logic [SW-1:0] i_starve_cnt,
    output pick_e         o_pick
);

    logic w_starved;

    assign w_starved = (i_starve_cnt == SW'(STARVE_LIMIT));

    // Choose the owner of the memory port for this cycle.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        o_pick = PICK_IDLE;
        if (i_locked) begin
            if (i_req0) begin
                o_pick = PICK_CORE;
            end
        end else if (i_req1 && (w_starved || !i_req0)) begin
            o_pick = PICK_IO;
        end else if (i_req0) begin
            o_pick = PICK_CORE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (core / IO) arbiter in front of a single-ported memory.
// Grants are combinational and complete in the granting cycle; read data
// returns one cycle later tagged with the port that issued the read.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int DW           = 16,
    parameter int AW           = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int LOCK_MAX     = LOCK_MAX_DEF
) (
    input  logic              CLK,
    input  logic              Rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int LW = cnt_width(LOCK_MAX);

    lock_state_e   r_lock_state;
    logic [LW-1:0] r_lock_cnt;
    logic          r_lock_err;
    logic [SW-1:0] r_starve_cnt;
    logic          r_rd_valid;
    port_e         r_rd_owner;

    pick_e         w_pick;
    logic          w_locked;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_mem_read;
    logic          w_mem_write;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [LW-1:0] w_lock_cnt_nxt;

    assign w_locked       = (r_lock_state == ST_LOCKED);
    assign w_lock_cnt_nxt = r_lock_cnt + 1'b1;

    arb_pick #(
        .SW           (SW),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .i_req0       (bus.Req0),
        .i_req1       (bus.Req1),
        .i_locked     (w_locked),
        .i_starve_cnt (r_starve_cnt),
        .o_pick       (w_pick)
    );

    // NOTE: grants are combinational, so they are gated by Rst_n directly;
    // the registers alone cannot keep them low while reset is held.
    assign w_gnt0 = Rst_n && (w_pick == PICK_CORE);
    assign w_gnt1 = Rst_n && (w_pick == PICK_IO);

    // Steer the granted port onto the memory port; idle drives zeros.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        if (w_gnt0) begin
            w_mem_addr  = bus.Addr0;
            w_mem_wdata = bus.WData0;
            w_mem_read  = !bus.Write0;
            w_mem_write = bus.Write0;
        end else if (w_gnt1) begin
            w_mem_addr  = bus.Addr1;
            w_mem_wdata = bus.WData1;
            w_mem_read  = !bus.Write1;
            w_mem_write = bus.Write1;
        end
    end

    assign bus.Gnt0     = w_gnt0;
    assign bus.Gnt1     = w_gnt1;
    assign bus.MemAddr  = w_mem_addr;
    assign bus.MemWData = w_mem_wdata;
    assign bus.MemRead  = w_mem_read;
    assign bus.MemWrite = w_mem_write;
    assign bus.RValid0  = r_rd_valid && (r_rd_owner == PORT_CORE);
    assign bus.RValid1  = r_rd_valid && (r_rd_owner == PORT_IO);
    assign bus.RData0   = bus.MemRData;
    assign bus.RData1   = bus.MemRData;
    assign bus.LockErr  = r_lock_err;

    // Lock FSM: tracks core ownership, counts locked cycles, flags forced release.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_lock_state <= ST_UNLOCKED;
            r_lock_cnt   <= '0;
            r_lock_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            r_lock_err <= 1'b0;
            case (r_lock_state)
                ST_UNLOCKED: begin
                    if (w_gnt0 && bus.Lock0) begin
                        r_lock_state <= ST_LOCKED;
                        r_lock_cnt   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_gnt0 && !bus.Lock0) begin
                        r_lock_state <= ST_UNLOCKED;
                        r_lock_cnt   <= '0;
                    end else if (w_lock_cnt_nxt == LW'(LOCK_MAX)) begin
                        r_lock_state <= ST_UNLOCKED;
                        r_lock_cnt   <= '0;
                        r_lock_err   <= 1'b1;
                    end else begin
                        r_lock_cnt   <= w_lock_cnt_nxt;
                    end
                end
                default: begin
                    r_lock_state <= ST_UNLOCKED;
                    r_lock_cnt   <= '0;
                end
            endcase
        end
    end

    // Starvation counter: core wins while IO waits count up, IO service or no IO demand clears.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_gnt1) begin
            r_starve_cnt <= '0;
        end else if (w_gnt0) begin
            if (!bus.Req1) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != SW'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else if (!w_locked && !bus.Req1) begin
            // A locked cycle without a core grant leaves the count alone.
            r_starve_cnt <= '0;
        end
    end

    // Read-return tag: remember that a read issued and which port owns it.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= PORT_CORE;
        end else begin
            r_rd_valid <= w_mem_read;
            r_rd_owner <= w_gnt1 ? PORT_IO : PORT_CORE;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes the expected
// per-cycle port activity into a queue; a negedge monitor pops and compares
// every cycle in which the DUT shows any grant, strobe, read-valid or LockErr.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.DW(16), .AW(16)) bus ();

    mem_port_arbiter #(
        .DW           (16),
        .AW           (16),
        .STARVE_LIMIT (3),
        .LOCK_MAX     (8)
    ) dut (
        .CLK   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: read data appears the cycle after MemRead.
    always @(posedge clk) begin
        if (bus.MemRead) bus.MemRData <= bus.MemAddr ^ 16'h5A5A;
    end

    typedef struct packed {
        logic [15:0] cyc;
        logic        g0;
        logic        g1;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rv0;
        logic        rv1;
        logic        lerr;
        logic [15:0] rdata;
    } ev_t;

    typedef struct {
        string name;
        ev_t   ev;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t observe();
        ev_t e;
        e.cyc   = cyc[15:0];
        e.g0    = bus.Gnt0;
        e.g1    = bus.Gnt1;
        e.rd    = bus.MemRead;
        e.wr    = bus.MemWrite;
        e.addr  = bus.MemAddr;
        e.wdata = bus.MemWData;
        e.rv0   = bus.RValid0;
        e.rv1   = bus.RValid1;
        e.lerr  = bus.LockErr;
        e.rdata = bus.RValid0 ? bus.RData0 : (bus.RValid1 ? bus.RData1 : 16'h0);
        return e;
    endfunction

    task automatic expect_ev(input string name, input logic g0, input logic g1,
                             input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic rv0, input logic rv1, input logic lerr,
                             input logic [15:0] rdata);
        exp_t x;
        x.name     = name;
        x.ev.cyc   = cyc[15:0];
        x.ev.g0    = g0;
        x.ev.g1    = g1;
        x.ev.rd    = rd;
        x.ev.wr    = wr;
        x.ev.addr  = addr;
        x.ev.wdata = wdata;
        x.ev.rv0   = rv0;
        x.ev.rv1   = rv1;
        x.ev.lerr  = lerr;
        x.ev.rdata = rdata;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0,
                         input logic [15:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [15:0] a1,
                         input logic [15:0] d1);
        bus.Req0   = r0;
        bus.Write0 = w0;
        bus.Addr0  = a0;
        bus.WData0 = d0;
        bus.Lock0  = l0;
        bus.Req1   = r1;
        bus.Write1 = w1;
        bus.Addr1  = a1;
        bus.WData1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check(name, {73'h0, bus.Gnt0, bus.Gnt1, bus.MemRead, bus.MemWrite,
                     bus.RValid0, bus.RValid1, bus.LockErr}, 80'h0);
    endtask

    // Monitor: any visible activity must match the next expected event.
    always @(negedge clk) begin
        ev_t o;
        exp_t e;
        o = observe();
        if (o.g0 || o.g1 || o.rd || o.wr || o.rv0 || o.rv1 || o.lerr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_activity", {9'h0, o}, 80'h0);
            end else begin
                e = exp_q.pop_front();
                check(e.name, {9'h0, o}, {9'h0, e.ev});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        // Requests asserted under reset must not leak through.
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        step();
        step();
        @(negedge clk);
        check_quiet("reset_outputs");

        step();
        idle();
        rst_n = 1'b1;

        // Simple core read, data returns next cycle to port 0.
        step();
        drive(1'b1, 1'b0, 16'h0010, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ev("core_read_grant", 1, 0, 1, 0, 16'h0010, 16'h1111, 0, 0, 0, 16'h0);
        step();
        idle();
        expect_ev("core_read_return", 0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h5A4A);

        // Alternating ports: write, IO read, core read, IO read, returns tagged in order.
        step();
        drive(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ev("alt_core_write", 1, 0, 0, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 16'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
        expect_ev("alt_io_read", 0, 1, 1, 0, 16'h0030, 16'h0, 0, 0, 0, 16'h0);
        step();
        drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ev("alt_core_read", 1, 0, 1, 0, 16'h0040, 16'h0, 0, 1, 0, 16'h5A6A);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0);
        expect_ev("alt_io_read2", 0, 1, 1, 0, 16'h0050, 16'h0, 1, 0, 0, 16'h5A1A);
        step();
        idle();
        expect_ev("alt_io_return", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h5A0A);

        // Both ports requesting continuously: 0,0,0,1,0,0,0,1.
        for (int i = 0; i < 8; i++) begin
            step();
            drive(1'b1, 1'b1, 16'h0100, 16'h0A0A, 1'b0, 1'b1, 1'b1, 16'h0200, 16'hCAFE);
            if (i == 3 || i == 7)
                expect_ev("starve_io_slot", 0, 1, 0, 1, 16'h0200, 16'hCAFE, 0, 0, 0, 16'h0);
            else
                expect_ev("starve_core_slot", 1, 0, 0, 1, 16'h0100, 16'h0A0A, 0, 0, 0, 16'h0);
        end
        step();
        idle();

        // Lock held across three IO-only cycles, then released by a core write.
        step();
        drive(1'b1, 1'b1, 16'h0300, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ev("lock_take", 1, 0, 0, 1, 16'h0300, 16'h1234, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0);
        end
        step();
        drive(1'b1, 1'b1, 16'h0301, 16'h5678, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0);
        expect_ev("lock_release_write", 1, 0, 0, 1, 16'h0301, 16'h5678, 0, 0, 0, 16'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0);
        expect_ev("io_after_unlock", 0, 1, 1, 0, 16'h0400, 16'h0, 0, 0, 0, 16'h0);
        step();
        idle();
        expect_ev("io_after_unlock_return", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h5E5A);

        // Lock never released: forced exit after 8 locked cycles, IO gets the next slot.
        for (int i = 0; i < 9; i++) begin
            step();
            drive(1'b1, 1'b1, 16'h0600, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h0);
            expect_ev("locked_core_write", 1, 0, 0, 1, 16'h0600, 16'h0F0F, 0, 0, 0, 16'h0);
        end
        step();
        drive(1'b1, 1'b1, 16'h0600, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h0);
        expect_ev("forced_unlock_io", 0, 1, 1, 0, 16'h0500, 16'h0, 0, 0, 1, 16'h0);
        step();
        idle();
        expect_ev("forced_unlock_return", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h5F5A);

        // Reset the cycle after a read grant: pending RValid is dropped.
        step();
        drive(1'b1, 1'b0, 16'h0070, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ev("pre_reset_read", 1, 0, 1, 0, 16'h0070, 16'h0, 0, 0, 0, 16'h0);
        step();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0070, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0080, 16'h0);
        @(negedge clk);
        check_quiet("midread_reset_outputs");
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0);
        rst_n = 1'b1;
        expect_ev("post_reset_io_read", 0, 1, 1, 0, 16'h0080, 16'h0, 0, 0, 0, 16'h0);
        step();
        idle();
        expect_ev("post_reset_io_return", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h5ADA);

        step();
        step();
        @(negedge clk);
        #1;
        check("queue_drained", 80'(exp_q.size()), 80'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DW, default 16: data width.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter STARVE_LIMIT, default 3: consecutive core grants while the IO port waits before the IO port is forced through.
REQ-004 Parameter LOCK_MAX, default 8: maximum cycles the core may hold the lock.
REQ-005 CLK  in  1  single system clock; all state updates on the rising edge.
REQ-006 Rst_n  in  1  asynchronous, active-low reset.
REQ-007 Req0  in  1  core request; Write0 (in, 1) selects write; Addr0 (in, AW); WData0 (in, DW).
REQ-008 Lock0  in  1  core asks to keep ownership after this transfer (stack read-modify-write).
REQ-009 Gnt0  out  1  core transfer accepted this cycle; RValid0 (out, 1) core read data valid; RData0 (out, DW).
REQ-010 Req1  in  1  IO request; Write1 (in, 1) selects write; Addr1 (in, AW); WData1 (in, DW).
REQ-011 Gnt1  out  1  IO transfer accepted this cycle; RValid1 (out, 1) IO read data valid; RData1 (out, DW).
REQ-012 MemAddr (out, AW), MemWData (out, DW), MemRead (out, 1), MemWrite (out, 1): single memory port; MemRData (in, DW) is valid one cycle after MemRead.
REQ-013 LockErr  out  1  one-cycle pulse on forced lock release.

Function
REQ-014 At most one of Gnt0/Gnt1 SHALL be high in any cycle; a grant is combinational and the transfer completes in the granting cycle.
REQ-015 A requester SHALL hold Req, Write, Addr and WData stable until granted; the arbiter does not buffer requests.
REQ-016 Priority, evaluated each cycle: (a) lock_q=1 -> core only, IO held off; (b) Req1 and (starve_cnt==STARVE_LIMIT or !Req0) -> IO; (c) Req0 -> core; (d) otherwise idle.
REQ-017 MemAddr/MemWData SHALL mux from the granted port; MemWrite = grant & Write; MemRead = grant & !Write; idle drives Addr/WData 0 and both strobes 0.
REQ-018 starve_cnt (2 bits minimum, saturating at STARVE_LIMIT): increments on a core grant with Req1 high; clears on an IO grant or when Req1 is low.
REQ-019 The lock FSM SHALL have two states. UNLOCKED -> LOCKED on a core grant with Lock0=1. LOCKED -> UNLOCKED on a core grant with Lock0=0, or when lock_cnt reaches LOCK_MAX.
REQ-020 lock_cnt SHALL count cycles in LOCKED and clear on entry to and exit from LOCKED; a forced exit pulses LockErr for one cycle.
REQ-021 In LOCKED with Req0 low, no grant SHALL occur, the cycle still counts, and starve_cnt is unchanged.
REQ-022 Read return: rd_valid_q/rd_owner_q SHALL register MemRead and the winning port; RValidN = rd_valid_q & (rd_owner_q==N) one cycle after the grant.
REQ-023 RData0 and RData1 SHALL both carry MemRData unqualified.
REQ-024 Back-to-back reads from alternating ports SHALL each return in order with correct RValid tagging; writes never raise RValid.
REQ-025 A forced IO slot (STARVE_LIMIT reached) SHALL occur even if Req0 is high, but never while LOCKED.

Reset
REQ-026 While Rst_n is low: lock FSM UNLOCKED; starve_cnt, lock_cnt, rd_valid_q, rd_owner_q = 0; Gnt0, Gnt1, MemRead, MemWrite, RValid0, RValid1, LockErr forced 0 regardless of inputs.
REQ-027 A reset asserted mid-read SHALL drop the pending RValid; the first grant is possible in the first rising edge cycle after Rst_n deasserts.

Structure
REQ-028 The port IDs (CORE=0, IO=1), lock FSM state encodings and the STARVE_LIMIT/LOCK_MAX defaults SHALL live in the shared mem_pkg package.
REQ-029 The priority/starvation decision SHALL be one sub-module, arb_pick, which is purely combinational; all registers stay in mem_port_arbiter.

Verification
REQ-030 Req0=1 (read, Addr0=0x0010), Req1=0 -> Gnt0 same cycle, MemRead=1, MemAddr=0x0010; next cycle RValid0=1, RValid1=0.
REQ-031 Req0 and Req1 held high continuously -> grant sequence 0,0,0,1,0,0,0,1 with STARVE_LIMIT=3.
REQ-032 Core grant with Lock0=1, then Req1 high and Req0 low for 3 cycles, then a core write with Lock0=0 -> Gnt1 stays 0 until the cycle after unlock; LockErr stays 0.
REQ-033 Lock0=1 held on every core grant with Req1 high -> forced unlock after 8 locked cycles, LockErr pulses once, and the next cycle grants IO.
REQ-034 Rst_n pulled low the cycle after a read grant -> RValid0 stays 0, all outputs 0; after release, Req1 read gets Gnt1 immediately.
